// File: rtl/dlfloat16_pkg.sv
// Shared definitions for the DLFloat16 add/sub issue block.
//   DLF16_NAN      : all-ones DLFloat16 pattern treated as NaN by the issue filter
//   ENA_ADDSUB     : 4-bit enable opcode selecting the add/sub unit
//   ENA_IDLE       : enable opcode when nothing is issued
//   EXC_*          : bit positions in the 5-bit exception vector
//   rsp_entry_t    : one response FIFO entry {result, exc, tag}
package dlfloat16_pkg;

  localparam logic [15:0] DLF16_NAN  = 16'hFFFF;
  localparam logic [3:0]  ENA_ADDSUB = 4'b0001;
  localparam logic [3:0]  ENA_IDLE   = 4'b0000;

  localparam int EXC_W         = 5;
  localparam int EXC_INVALID   = 4;
  localparam int EXC_INEXACT   = 3;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_DIV_ZERO  = 0;

  // Exception vector reported for a request that was filtered instead of issued.
  localparam logic [EXC_W-1:0] EXC_NAN_BYPASS = 5'b10000;

  // Tag width carried in the FIFO entry; the top-level TAG_W is expected to match.
  localparam int RSP_TAG_W = 4;

  typedef struct packed {
    logic [15:0]          result;
    logic [EXC_W-1:0]     exc;
    logic [RSP_TAG_W-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/dlfloat16_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t with wrap-bit pointers.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (pointers only)
//   i_push        : write i_push_data at the tail
//   i_push_data   : entry to write
//   i_pop         : remove the head entry (ignored when empty)
//   o_head        : current head entry (undefined when empty)
//   o_empty       : no entries stored
//   o_full        : DEPTH entries stored
//   o_count       : current occupancy, 0..DEPTH
module dlfloat16_rsp_fifo
  import dlfloat16_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  rsp_entry_t    i_push_data,
  input  logic          i_pop,
  output rsp_entry_t    o_head,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  rsp_entry_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_pop;

  // Same index with differing wrap bits means the write pointer lapped the read pointer.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  // The issuer's credit scheme must never let a capture land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));

endmodule

// File: rtl/dlfloat16_fpu_issue.sv
// Initiator side of the DLFloat16 add/sub datapath.
// Accepts tagged requests, registers operands into the add/sub unit with a
// one-cycle ENA_ADDSUB pulse, tracks the fixed FPU_LAT result latency with a
// tag pipe, captures {result, exceptions} into an in-order response FIFO and
// keeps sticky exception flags of everything popped.
// Optional build macro: DLF16_ISSUE_NAN_FILTER_EN -- requests with an operand
// equal to 16'hFFFF are accepted but not issued; they return FFFF / 5'b10000
// in order through the same pipe.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready     : request handshake (ready from credit counts only)
//   i_req_op, i_req_a, i_req_b  : 0=add/1=sub, DLFloat16 operands
//   i_req_tag                   : returned unchanged with the response
//   o_fpu_a/o_fpu_b/o_fpu_op    : registered operands/op to the add/sub unit
//   o_fpu_ena                   : ENA_ADDSUB for one cycle per issue, else ENA_IDLE
//   i_fpu_c_out, i_fpu_exc      : add/sub result (bits[15:0]) and exceptions
//   o_rsp_valid/i_rsp_ready     : response handshake
//   o_rsp_result/exc/tag        : FIFO head (zero when empty)
//   o_flags, i_clr_flags        : sticky OR of popped exceptions, synchronous clear
module dlfloat16_fpu_issue
  import dlfloat16_pkg::*;
#(
  parameter int FPU_LAT   = 1,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = RSP_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_op,
  input  logic [15:0]      i_req_a,
  input  logic [15:0]      i_req_b,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic [15:0]      o_fpu_a,
  output logic [15:0]      o_fpu_b,
  output logic             o_fpu_op,
  output logic [3:0]       o_fpu_ena,
  input  logic [31:0]      i_fpu_c_out,
  input  logic [4:0]       i_fpu_exc,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [15:0]      o_rsp_result,
  output logic [4:0]       o_rsp_exc,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [4:0]       o_flags,
  input  logic             i_clr_flags
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic             w_accept;
  logic             w_nan_req;
  logic             w_cap;
  logic             w_pop;
  logic [CW-1:0]    w_occ;
  logic [CW:0]      w_credit_sum;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  rsp_entry_t       w_push_entry;
  rsp_entry_t       w_head;
  logic             w_unused;

  logic [15:0]      r_fpu_a;
  logic [15:0]      r_fpu_b;
  logic             r_fpu_op;
  logic [3:0]       r_fpu_ena;
  logic [CW-1:0]    r_inflight;
  logic [4:0]       r_flags;

  // Stage 0 coincides with the o_fpu_ena cycle; stage FPU_LAT is the cycle the
  // add/sub result is valid and gets captured.
  logic [FPU_LAT:0] r_vld_p;
  logic [FPU_LAT:0] r_byp_p;
  logic [TAG_W-1:0] r_tag_p [FPU_LAT+1];

`ifdef DLF16_ISSUE_NAN_FILTER_EN
  assign w_nan_req = (i_req_a == DLF16_NAN) || (i_req_b == DLF16_NAN);
`else
  assign w_nan_req = 1'b0;
`endif

  // Credits count both ops still in the FPU and entries waiting in the FIFO,
  // so every capture is guaranteed a free slot.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_occ};
  assign o_req_ready  = (w_credit_sum < (CW+1)'(RSP_DEPTH));
  assign w_accept     = i_req_valid & o_req_ready;
  assign w_cap        = r_vld_p[FPU_LAT];
  assign w_pop        = o_rsp_valid & i_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpu_a    <= '0;
      r_fpu_b    <= '0;
      r_fpu_op   <= 1'b0;
      r_fpu_ena  <= ENA_IDLE;
      r_vld_p    <= '0;
      r_inflight <= '0;
    end else begin
      r_fpu_ena <= ENA_IDLE;
      if (w_accept && !w_nan_req) begin
        r_fpu_a   <= i_req_a;
        r_fpu_b   <= i_req_b;
        r_fpu_op  <= i_req_op;
        r_fpu_ena <= ENA_ADDSUB;
      end
      r_vld_p    <= {r_vld_p[FPU_LAT-1:0], w_accept};
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_cap);
    end
  end

  // Tag and bypass bits are qualified by r_vld_p, so they need no reset.
  always_ff @(posedge clk) begin
    r_tag_p[0] <= i_req_tag;
    r_byp_p    <= {r_byp_p[FPU_LAT-1:0], w_nan_req};
    for (int i = 1; i <= FPU_LAT; i++) begin
      r_tag_p[i] <= r_tag_p[i-1];
    end
  end

  // ---- capture stage: FPU result enters the response FIFO ----
  always_comb begin
    w_push_entry.result = r_byp_p[FPU_LAT] ? DLF16_NAN      : i_fpu_c_out[15:0];
    w_push_entry.exc    = r_byp_p[FPU_LAT] ? EXC_NAN_BYPASS : i_fpu_exc;
    w_push_entry.tag    = RSP_TAG_W'(r_tag_p[FPU_LAT]);
  end

  dlfloat16_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_cap),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_count     (w_occ)
  );

  // Clear takes effect before the OR so a coincident pop leaves only its own exc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_pop) begin
      r_flags <= (i_clr_flags ? 5'b0 : r_flags) | w_head.exc;
    end else if (i_clr_flags) begin
      r_flags <= '0;
    end
  end

  // Head fields are masked so stale storage never shows on the response port.
  assign o_rsp_valid  = ~w_fifo_empty;
  assign o_rsp_result = o_rsp_valid ? w_head.result : 16'h0;
  assign o_rsp_exc    = o_rsp_valid ? w_head.exc    : 5'h0;
  assign o_rsp_tag    = o_rsp_valid ? TAG_W'(w_head.tag) : '0;

  assign o_fpu_a   = r_fpu_a;
  assign o_fpu_b   = r_fpu_b;
  assign o_fpu_op  = r_fpu_op;
  assign o_fpu_ena = r_fpu_ena;
  assign o_flags   = r_flags;

  // Upper result half is outside the DLFloat16 format; full is implied by credits.
  assign w_unused = ^{i_fpu_c_out[31:16], w_fifo_full};

endmodule

// File: tb/tb_dlfloat16_fpu_issue.sv
module tb_dlfloat16_fpu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [15:0] fpu_a, fpu_b;
  logic        fpu_op;
  logic [3:0]  fpu_ena;
  logic [31:0] fpu_c_out = '0;
  logic [4:0]  fpu_exc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_exc;
  logic [3:0]  rsp_tag;
  logic [4:0]  flags;
  logic        clr_flags = 1'b0;

  int total = 0;
  int bad = 0;
  int last_wait = 0;
  int ena_cnt = 0;

  typedef struct {
    logic [15:0] r;
    logic [4:0]  e;
    logic [3:0]  t;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dlfloat16_fpu_issue #(.FPU_LAT(1), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_tag(req_tag),
    .o_fpu_a(fpu_a), .o_fpu_b(fpu_b), .o_fpu_op(fpu_op), .o_fpu_ena(fpu_ena),
    .i_fpu_c_out(fpu_c_out), .i_fpu_exc(fpu_exc),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_result(rsp_result),
    .o_rsp_exc(rsp_exc), .o_rsp_tag(rsp_tag),
    .o_flags(flags), .i_clr_flags(clr_flags)
  );

  // Stand-in add/sub unit with one cycle of latency: exact answers for the
  // hand-checked vectors, a fixed scramble of the operands otherwise.
  function automatic logic [20:0] fpu_model(input logic [15:0] a, input logic [15:0] b, input logic op);
    if (a == 16'h3E00 && b == 16'h3E00 && !op) return {16'h4000, 5'b0};
    if (a == 16'h4000 && b == 16'h3E00 &&  op) return {16'h3E00, 5'b0};
    return {a ^ {b[7:0], b[15:8]} ^ {15'd0, op}, a[4:0] ^ b[4:0]};
  endfunction

  always @(posedge clk) begin
    if (fpu_ena == 4'b0001) begin
      fpu_c_out <= {16'hDEAD, fpu_model(fpu_a, fpu_b, fpu_op)[20:5]};
      fpu_exc   <= fpu_model(fpu_a, fpu_b, fpu_op)[4:0];
    end
  end

  always @(negedge clk) begin
    if (fpu_ena == 4'b0001) ena_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every popped response is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got tag=%h res=%h exc=%h want none", rsp_tag, rsp_result, rsp_exc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp {tag,exc,res}", {7'd0, rsp_tag, rsp_exc, rsp_result}, {7'd0, e.t, e.e, e.r});
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                      input logic [3:0] tag, input logic [15:0] er, input logic [4:0] ee);
    int n = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_tag = tag;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!req_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back('{er, ee, tag});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic op, input logic [3:0] tag);
    logic [20:0] m;
    m = fpu_model(a, b, op);
    send(a, b, op, tag, m[20:5], m[4:0]);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] fl;
    int waits;
    int e0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst fpu_ena", fpu_ena, 0);
    chk("rst fpu_a/b/op", {fpu_a, fpu_b, 15'd0, fpu_op}, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst flags", flags, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle req_ready", req_ready, 1);

    // 1: 1.0 + 1.0, ena pulse and response latency
    rsp_ready = 1'b1;
    send(16'h3E00, 16'h3E00, 1'b0, 4'h5, 16'h4000, 5'h00);
    chk("t1 ena pulse", fpu_ena, 4'b0001);
    chk("t1 fpu_a", fpu_a, 16'h3E00);
    chk("t1 rsp_valid +1", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t1 ena one cycle", fpu_ena, 4'b0000);
    chk("t1 rsp_valid +1b", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t1 rsp_valid +2", rsp_valid, 1);
    drain();

    // 2: 2.0 - 1.0
    send(16'h4000, 16'h3E00, 1'b1, 4'h6, 16'h3E00, 5'h00);
    chk("t2 fpu_op", fpu_op, 1);
    drain();
    chk("t2 flags", flags, 0);

    // 3: fill credits with the consumer stalled, then release
    rsp_ready = 1'b0;
    fl = 5'h0;
    for (int i = 0; i < 4; i++) begin
      send_m(16'h1230 + 16'(i), 16'h0450 + 16'(2 * i), 1'b0, 4'(i));
      fl |= fpu_model(16'h1230 + 16'(i), 16'h0450 + 16'(2 * i), 1'b0)[4:0];
    end
    chk("t3 ready low after 4th", req_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t3 ready held low", req_ready, 0);
    chk("t3 flags before pop", flags, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3 ready after first pop", req_ready, 1);
    drain();
    chk("t3 sticky flags", flags, {27'd0, fl});

    // clear coinciding with a pop keeps only that pop's exceptions
    rsp_ready = 1'b0;
    send_m(16'h0011, 16'h0001, 1'b0, 4'hA);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("clr+pop valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    chk("clr+pop flags", flags, 5'h10);
    clr_pulse();
    chk("clr flags", flags, 0);

    // 4: reset with two in flight and one queued
    rsp_ready = 1'b0;
    send_m(16'h0101, 16'h0202, 1'b0, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    send_m(16'h0303, 16'h0404, 1'b1, 4'h2);
    send_m(16'h0505, 16'h0606, 1'b0, 4'h3);
    chk("t4 queued before rst", rsp_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t4 rst fpu", {fpu_a, fpu_b, 11'd0, fpu_op, fpu_ena}, 0);
    chk("t4 rst rsp", {6'd0, rsp_valid, rsp_result, rsp_exc, rsp_tag}, 0);
    chk("t4 rst flags", flags, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4 no stale rsp", rsp_valid, 0);
    chk("t4 ready after rst", req_ready, 1);

    // 5: all-ones operand between two normal ops
    e0 = ena_cnt;
`ifdef DLF16_ISSUE_NAN_FILTER_EN
    send(16'h3E00, 16'h3E00, 1'b0, 4'h7, 16'h4000, 5'h00);
    send(16'hFFFF, 16'h3E00, 1'b0, 4'h8, 16'hFFFF, 5'b10000);
    send(16'h4000, 16'h3E00, 1'b1, 4'h9, 16'h3E00, 5'h00);
    drain();
    chk("t5 ena pulses", ena_cnt - e0, 2);
    chk("t5 flags", flags, 5'b10000);
    repeat (2) @(posedge clk);
    #1;
    chk("t5 flags sticky", flags, 5'b10000);
    clr_pulse();
    chk("t5 flags cleared", flags, 0);
`else
    send_m(16'hFFFF, 16'h3E00, 1'b0, 4'h8);
    drain();
    chk("t5 ena pulses", ena_cnt - e0, 1);
    clr_pulse();
`endif

    // 6: streaming accept and pop every cycle
    rsp_ready = 1'b1;
    waits = 0;
    for (int i = 0; i < 64; i++) begin
      send_m(16'h2000 + 16'(i) * 16'h0101, 16'h0F0F ^ 16'(i * 7), 1'(i), 4'(i));
      if (i > 0) waits += last_wait;
    end
    chk("t6 ready never dropped", waits, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
